tp_tap_encoder: RTL

Touch-front-end block that produces the `tp_x_coord`/`tp_y_coord` and `move_on` signals consumed by the game state machine and game controller. It turns the panel driver's level-type touch report into a single-cycle, debounced, range-clamped tap event, and turns the physical advance key into a one-cycle `move_on` pulse. It sits between the touch-panel driver and the game state machine, in the `clk` domain.

---
 rtl/tp_tap_encoder.sv | 113 +++++++++++
 1 files changed

// File: rtl/tp_tap_encoder.sv
// tp_tap_encoder: debounced, clamped single-cycle tap events plus a debounced advance-key pulse
module tp_tap_encoder #(
    parameter int          PRESS_CYCLES    = 50000,
    parameter int          RELEASE_CYCLES  = 500000,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          H_RES           = 800,
    parameter int          V_RES           = 480,
    parameter logic [15:0] PARK_X          = 16'd0,
    parameter logic [15:0] PARK_Y          = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        touch_valid,
    input  logic [15:0] raw_x,
    input  logic [15:0] raw_y,
    input  logic        key_n,
    output logic [15:0] tp_x_coord,
    output logic [15:0] tp_y_coord,
    output logic        tap_valid,
    output logic        move_on
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRESS = 3'd1;
    localparam logic [2:0] S_TAP   = 3'd2;
    localparam logic [2:0] S_HELD  = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    if (PRESS_CYCLES < 2 || RELEASE_CYCLES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad
        $error("tp_tap_encoder: cycle parameters must be >= 2");
    end

    logic [2:0]  r_state, w_next;
    logic [31:0] r_cnt, w_cnt;
    logic [15:0] w_x, w_y;
    logic        w_tap;
    logic        r_key_s1, r_key_s2, r_key_deb, r_key_deb_d;
    logic [31:0] r_key_cnt;

    assign w_x   = (raw_x >= 16'(H_RES)) ? 16'(H_RES - 1) : raw_x;
    assign w_y   = (raw_y >= 16'(V_RES)) ? 16'(V_RES - 1) : raw_y;
    assign w_tap = (w_next == S_TAP);

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            S_IDLE: if (touch_valid) begin
                w_next = S_PRESS;
                w_cnt  = 32'd1;
            end
            S_PRESS: begin
                w_next = !touch_valid ? S_IDLE :
                         (r_cnt == 32'(PRESS_CYCLES - 1)) ? S_TAP : S_PRESS;
                w_cnt  = (w_next == S_PRESS) ? r_cnt + 32'd1 : 32'd0;
            end
            S_TAP: w_next = S_HELD;
            S_HELD: if (!touch_valid) begin
                w_next = S_REL;
                w_cnt  = 32'd1;
            end
            S_REL: begin
                w_next = touch_valid ? S_HELD :
                         (r_cnt == 32'(RELEASE_CYCLES - 1)) ? S_IDLE : S_REL;
                w_cnt  = (w_next == S_REL) ? r_cnt + 32'd1 : 32'd0;
            end
            default: begin
                w_next = S_IDLE;
                w_cnt  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'd0;
            tap_valid  <= 1'b0;
            tp_x_coord <= PARK_X;
            tp_y_coord <= PARK_Y;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            tap_valid  <= w_tap;
            tp_x_coord <= w_tap ? w_x : PARK_X;
            tp_y_coord <= w_tap ? w_y : PARK_Y;
        end
    end

    // key level is accepted only after it differs from the debounced level for the full window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1    <= 1'b1;
            r_key_s2    <= 1'b1;
            r_key_deb   <= 1'b1;
            r_key_deb_d <= 1'b1;
            r_key_cnt   <= 32'd0;
            move_on     <= 1'b0;
        end else begin
            r_key_s1    <= key_n;
            r_key_s2    <= r_key_s1;
            r_key_deb_d <= r_key_deb;
            move_on     <= r_key_deb_d & ~r_key_deb;
            if (r_key_s2 == r_key_deb) begin
                r_key_cnt <= 32'd0;
            end else if (r_key_cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
                r_key_deb <= r_key_s2;
                r_key_cnt <= 32'd0;
            end else begin
                r_key_cnt <= r_key_cnt + 32'd1;
            end
        end
    end
endmodule
